// File: rtl/cache_bus_pkg.sv
// Shared definitions for the snooping cache bus: request/response codes, the
// arbiter FSM state encoding and the block-address width helper.
package cache_bus_pkg;

    typedef enum logic [1:0] {
        BUS_NO_REQ = 2'b00,
        BUS_RD     = 2'b01,
        BUS_RDX    = 2'b10,
        BUS_UPGR   = 2'b11
    } bus_req_e;

    typedef enum logic [1:0] {
        BUS_NO_RSP     = 2'b00,
        BUS_RSP_SHARED = 2'b01,
        BUS_RSP_FLUSH  = 2'b10,
        BUS_RSP_EXCL   = 2'b11
    } bus_rsp_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SNOOP  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WB = 3'd3,
        ST_RSP    = 3'd4
    } bus_state_e;

    // Block address width: byte address minus the offset bits inside one line.
    function automatic int blk_w(input int addr_w, input int line_w);
        return addr_w - $clog2(line_w / 8);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping around, and reports both a one-hot grant and the granted index.
module rr_arbiter
    import cache_bus_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snooping bus arbiter: one transaction at a time, snoop broadcast, flush or
// memory sourcing of the line, then a single completion to the requester.
module snoop_bus_arbiter
    import cache_bus_pkg::*;
#(
    parameter int  NUM_CACHE  = 4,
    parameter int  LINE_WIDTH = 512,
    parameter int  ADDR_WIDTH = 64,
    parameter int  SNOOP_LAT  = 2,
    localparam int BLK_W      = blk_w(ADDR_WIDTH, LINE_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [2*NUM_CACHE-1:0]          cac2bus_bus_req,
    input  logic [BLK_W*NUM_CACHE-1:0]      cac2bus_addr,
    input  logic [2*NUM_CACHE-1:0]          cac2bus_bus_rsp,
    input  logic [LINE_WIDTH*NUM_CACHE-1:0] cac2bus_data,
    input  logic [NUM_CACHE-1:0]            cac2bus_write_back,
    output logic [2*NUM_CACHE-1:0]          bus2cac_bus_req,
    output logic [2*NUM_CACHE-1:0]          bus2cac_bus_rsp,
    output logic [BLK_W-1:0]                bus2cac_addr,
    output logic [LINE_WIDTH-1:0]           bus2cac_data,
    output logic                            mem_rd_req,
    output logic                            mem_wr_req,
    output logic [BLK_W-1:0]                mem_addr,
    output logic [LINE_WIDTH-1:0]           mem_wdata,
    input  logic [LINE_WIDTH-1:0]           mem_rdata,
    input  logic                            mem_ack,
    output logic                            err_multi_flush
);

    localparam int IDX_W = $clog2(NUM_CACHE);
    localparam int CNT_W = $clog2(SNOOP_LAT + 1);

    logic [1:0]            req_arr  [NUM_CACHE];
    logic [1:0]            rsp_arr  [NUM_CACHE];
    logic [BLK_W-1:0]      addr_arr [NUM_CACHE];
    logic [LINE_WIDTH-1:0] data_arr [NUM_CACHE];
    logic [NUM_CACHE-1:0]  cand_vec;

    for (genvar g = 0; g < NUM_CACHE; g++) begin : g_unpack
        assign req_arr[g]  = cac2bus_bus_req[2*g +: 2];
        assign rsp_arr[g]  = cac2bus_bus_rsp[2*g +: 2];
        assign addr_arr[g] = cac2bus_addr[BLK_W*g +: BLK_W];
        assign data_arr[g] = cac2bus_data[LINE_WIDTH*g +: LINE_WIDTH];
        assign cand_vec[g] = |req_arr[g];
    end

    bus_state_e            state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      req_idx_q, req_idx_d;
    bus_req_e              code_q, code_d;
    logic [BLK_W-1:0]      addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  shared_q, shared_d;
    logic                  flush_q, flush_d;
    logic [IDX_W-1:0]      flush_idx_q, flush_idx_d;
    logic [NUM_CACHE-1:0]  flush_mask_q, flush_mask_d;
    logic [LINE_WIDTH-1:0] data_q, data_d;

    logic [NUM_CACHE-1:0]  arb_grant;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_valid;

    rr_arbiter #(
        .N     (NUM_CACHE),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i   (cand_vec),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    logic [1:0]           sel_code;
    logic [BLK_W-1:0]     sel_addr;
    logic                 cur_shared;
    logic [NUM_CACHE-1:0] cur_mask;
    logic [IDX_W-1:0]     cur_low;

    // Requester's own response slice never counts towards the snoop result.
    always_comb begin
        sel_code   = '0;
        sel_addr   = '0;
        cur_shared = 1'b0;
        cur_mask   = '0;
        cur_low    = '0;
        for (int j = 0; j < NUM_CACHE; j++) begin
            if (arb_grant[j]) begin
                sel_code = req_arr[j];
                sel_addr = addr_arr[j];
            end
            if (IDX_W'(j) != req_idx_q) begin
                if (rsp_arr[j] == BUS_RSP_SHARED || rsp_arr[j] == BUS_RSP_FLUSH)
                    cur_shared = 1'b1;
                if (rsp_arr[j] == BUS_RSP_FLUSH && cac2bus_write_back[j])
                    cur_mask[j] = 1'b1;
            end
        end
        for (int j = NUM_CACHE - 1; j >= 0; j--) begin
            if (cur_mask[j])
                cur_low = IDX_W'(j);
        end
    end

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        req_idx_d       = req_idx_q;
        code_d          = code_q;
        addr_d          = addr_q;
        cnt_d           = cnt_q;
        shared_d        = shared_q;
        flush_d         = flush_q;
        flush_idx_d     = flush_idx_q;
        flush_mask_d    = flush_mask_q;
        data_d          = data_q;
        bus2cac_bus_req = '0;
        bus2cac_bus_rsp = '0;
        bus2cac_addr    = '0;
        bus2cac_data    = '0;
        mem_rd_req      = 1'b0;
        mem_wr_req      = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        err_multi_flush = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    req_idx_d    = arb_idx;
                    code_d       = bus_req_e'(sel_code);
                    addr_d       = sel_addr;
                    ptr_d        = (int'(arb_idx) == NUM_CACHE - 1) ? '0 : arb_idx + 1'b1;
                    cnt_d        = '0;
                    shared_d     = 1'b0;
                    flush_d      = 1'b0;
                    flush_idx_d  = '0;
                    flush_mask_d = '0;
                    state_d      = ST_SNOOP;
                end
            end
            ST_SNOOP: begin
                for (int j = 0; j < NUM_CACHE; j++) begin
                    if (IDX_W'(j) != req_idx_q)
                        bus2cac_bus_req[2*j +: 2] = code_q;
                end
                bus2cac_addr = addr_q;
                shared_d     = shared_q | cur_shared;
                flush_mask_d = flush_mask_q | cur_mask;
                flush_d      = flush_q | (|cur_mask);
                // Lowest-index flusher owns the line even if it shows up late.
                if ((|cur_mask) && (!flush_q || cur_low < flush_idx_q)) begin
                    flush_idx_d = cur_low;
                    data_d      = data_arr[cur_low];
                end
                if (cnt_q == CNT_W'(SNOOP_LAT - 1)) begin
                    err_multi_flush = |(flush_mask_d & (flush_mask_d - NUM_CACHE'(1)));
                    if (flush_d)
                        state_d = ST_MEM_WB;
                    else if (code_q == BUS_UPGR)
                        state_d = ST_RSP;
                    else
                        state_d = ST_MEM_RD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MEM_RD: begin
                mem_rd_req = 1'b1;
                mem_addr   = addr_q;
                if (mem_ack) begin
                    data_d  = mem_rdata;
                    state_d = ST_RSP;
                end
            end
            ST_MEM_WB: begin
                mem_wr_req = 1'b1;
                mem_addr   = addr_q;
                mem_wdata  = data_q;
                if (mem_ack)
                    state_d = ST_RSP;
            end
            ST_RSP: begin
                for (int j = 0; j < NUM_CACHE; j++) begin
                    if (IDX_W'(j) == req_idx_q)
                        bus2cac_bus_rsp[2*j +: 2] = (code_q == BUS_RD && shared_q) ?
                                                    BUS_RSP_SHARED : BUS_RSP_EXCL;
                end
                bus2cac_addr = addr_q;
                bus2cac_data = (code_q == BUS_UPGR) ? '0 : data_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            req_idx_q    <= '0;
            code_q       <= BUS_NO_REQ;
            addr_q       <= '0;
            cnt_q        <= '0;
            shared_q     <= 1'b0;
            flush_q      <= 1'b0;
            flush_idx_q  <= '0;
            flush_mask_q <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            req_idx_q    <= req_idx_d;
            code_q       <= code_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            shared_q     <= shared_d;
            flush_q      <= flush_d;
            flush_idx_q  <= flush_idx_d;
            flush_mask_q <= flush_mask_d;
            data_q       <= data_d;
        end
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Scoreboard bench for snoop_bus_arbiter: completions are predicted when a
// request is issued and compared as the arbiter drives its response.
module tb_snoop_bus_arbiter;
    import cache_bus_pkg::*;

    localparam int NC = 4;
    localparam int LW = 512;
    localparam int AW = 64;
    localparam int SL = 2;
    localparam int BW = blk_w(AW, LW);

    logic              clk = 1'b0;
    logic              rst;
    logic [2*NC-1:0]   cacReq;
    logic [BW*NC-1:0]  cacAddr;
    logic [2*NC-1:0]   cacRsp;
    logic [LW*NC-1:0]  cacData;
    logic [NC-1:0]     cacWb;
    logic [2*NC-1:0]   busReq;
    logic [2*NC-1:0]   busRsp;
    logic [BW-1:0]     busAddr;
    logic [LW-1:0]     busData;
    logic              memRd;
    logic              memWr;
    logic [BW-1:0]     memAddr;
    logic [LW-1:0]     memWdata;
    logic [LW-1:0]     memRdata;
    logic              memAck;
    logic              errMulti;

    snoop_bus_arbiter #(
        .NUM_CACHE  (NC),
        .LINE_WIDTH (LW),
        .ADDR_WIDTH (AW),
        .SNOOP_LAT  (SL)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cac2bus_bus_req    (cacReq),
        .cac2bus_addr       (cacAddr),
        .cac2bus_bus_rsp    (cacRsp),
        .cac2bus_data       (cacData),
        .cac2bus_write_back (cacWb),
        .bus2cac_bus_req    (busReq),
        .bus2cac_bus_rsp    (busRsp),
        .bus2cac_addr       (busAddr),
        .bus2cac_data       (busData),
        .mem_rd_req         (memRd),
        .mem_wr_req         (memWr),
        .mem_addr           (memAddr),
        .mem_wdata          (memWdata),
        .mem_rdata          (memRdata),
        .mem_ack            (memAck),
        .err_multi_flush    (errMulti)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cache;
        logic [1:0]  rsp;
        logic [LW-1:0] data;
    } expRsp_t;

    expRsp_t sbQueue[$];

    int compCount = 0;
    int failCount = 0;
    int cycleCount = 0;
    int snoopCycles, firstSnoopCyc, rspSeen, rspCyc;
    int memRdCycles, memWrCycles, bothCycles, errPulses;
    logic [2*NC-1:0] lastSnoop;
    logic [BW-1:0]   snoopAddr, lastMemAddr;
    logic [LW-1:0]   lastWdata;
    int memLat = 3;
    int memCnt = 0;
    bit memEnable = 1'b1;

    task automatic checkOutput(input string tag, input logic [LW-1:0] observed,
                               input logic [LW-1:0] expected);
        compCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [LW-1:0] lineFor(input logic [BW-1:0] a);
        logic [63:0] w;
        w = 64'hD00D_0000_0000_0000 | 64'(a);
        return {8{w}};
    endfunction

    function automatic logic [2*NC-1:0] rspVec(input int cache, input logic [1:0] code);
        logic [2*NC-1:0] v;
        v = '0;
        v[2*cache +: 2] = code;
        return v;
    endfunction

    function automatic logic [2*NC-1:0] snoopVec(input int req, input logic [1:0] code);
        logic [2*NC-1:0] v;
        v = '0;
        for (int j = 0; j < NC; j++)
            if (j != req) v[2*j +: 2] = code;
        return v;
    endfunction

    always @(posedge clk) cycleCount++;

    // Memory model: acknowledges each request memLat cycles after it appears.
    always @(negedge clk) begin
        if (memEnable && !rst) begin
            if (memAck) begin
                memAck = 1'b0;
                memCnt = 0;
            end else if (memRd || memWr) begin
                memCnt++;
                if (memCnt == memLat) begin
                    memAck   = 1'b1;
                    memRdata = lineFor(memAddr);
                end
            end
        end
    end

    // Observe the bus mid-cycle and retire scoreboard entries on completions.
    always @(negedge clk) begin
        expRsp_t e;
        if (!rst) begin
            if (busReq != '0) begin
                snoopCycles++;
                lastSnoop = busReq;
                snoopAddr = busAddr;
                if (firstSnoopCyc < 0) firstSnoopCyc = cycleCount;
            end
            if (memRd) begin
                memRdCycles++;
                lastMemAddr = memAddr;
            end
            if (memWr) begin
                memWrCycles++;
                lastMemAddr = memAddr;
                lastWdata   = memWdata;
            end
            if (memRd && memWr) bothCycles++;
            if (errMulti) errPulses++;
            if (busRsp != '0) begin
                rspSeen++;
                rspCyc = cycleCount;
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpectedRsp", LW'(busRsp), '0);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("rspVector", LW'(busRsp), LW'(rspVec(e.cache, e.rsp)));
                    checkOutput("rspData", busData, e.data);
                end
            end
        end
    end

    task automatic clearStats();
        snoopCycles   = 0;
        firstSnoopCyc = -1;
        rspSeen       = 0;
        rspCyc        = 0;
        memRdCycles   = 0;
        memWrCycles   = 0;
        errPulses     = 0;
        lastSnoop     = '0;
        snoopAddr     = '0;
        lastMemAddr   = '0;
        lastWdata     = '0;
    endtask

    task automatic pushExp(input int cache, input logic [1:0] rsp, input logic [LW-1:0] data);
        expRsp_t e;
        e.cache = cache;
        e.rsp   = rsp;
        e.data  = data;
        sbQueue.push_back(e);
    endtask

    task automatic applyStimulus(input int cache, input logic [1:0] code, input logic [BW-1:0] addr);
        cacReq[2*cache +: 2]   = code;
        cacAddr[BW*cache +: BW] = addr;
    endtask

    task automatic setSnoopRsp(input int cache, input logic [1:0] rsp, input logic wb,
                               input logic [LW-1:0] data);
        cacRsp[2*cache +: 2]    = rsp;
        cacWb[cache]            = wb;
        cacData[LW*cache +: LW] = data;
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic waitSnoopStart();
        int n = 0;
        while (firstSnoopCyc < 0 && n < 50) begin
            nextCycle();
            n++;
        end
        if (firstSnoopCyc < 0) checkOutput("snoopTimeout", LW'(0), LW'(1));
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sbQueue.size() != 0 && n < 200) begin
            nextCycle();
            n++;
        end
        if (sbQueue.size() != 0) checkOutput("drainTimeout", LW'(sbQueue.size()), LW'(0));
        repeat (2) nextCycle();
    endtask

    task automatic issueSingle(input int cache, input logic [1:0] code, input logic [BW-1:0] addr);
        applyStimulus(cache, code, addr);
        waitSnoopStart();
        applyStimulus(cache, BUS_NO_REQ, addr);
        waitDrain();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst      = 1'b1;
        cacReq   = '0;
        cacAddr  = '0;
        cacRsp   = '0;
        cacData  = '0;
        cacWb    = '0;
        memRdata = '0;
        memAck   = 1'b0;
        clearStats();
        bothCycles = 0;
        repeat (2) nextCycle();
        checkOutput("resetOutputs", LW'({memRd, memWr, |busReq, |busRsp, |busAddr,
                    |busData, |memAddr, |memWdata, errMulti}), '0);
        rst = 1'b0;
        repeat (2) nextCycle();

        $display("[TB] single RD from cache 1, line supplied by memory");
        clearStats();
        pushExp(1, BUS_RSP_EXCL, lineFor(BW'(64'h40)));
        issueSingle(1, BUS_RD, BW'(64'h40));
        checkOutput("rdSnoopCycles", LW'(snoopCycles), LW'(SL));
        checkOutput("rdSnoopVec", LW'(lastSnoop), LW'(snoopVec(1, BUS_RD)));
        checkOutput("rdSnoopAddr", LW'(snoopAddr), LW'(64'h40));
        checkOutput("rdMemRdCycles", LW'(memRdCycles), LW'(memLat));
        checkOutput("rdMemAddr", LW'(lastMemAddr), LW'(64'h40));
        checkOutput("rdMemWr", LW'(memWrCycles), LW'(0));

        $display("[TB] RD from cache 0 with cache 2 flushing");
        clearStats();
        setSnoopRsp(2, BUS_RSP_FLUSH, 1'b1, {64{8'hA5}});
        pushExp(0, BUS_RSP_SHARED, {64{8'hA5}});
        issueSingle(0, BUS_RD, BW'(64'h80));
        setSnoopRsp(2, BUS_NO_RSP, 1'b0, '0);
        checkOutput("wbMemWrCycles", LW'(memWrCycles), LW'(memLat));
        checkOutput("wbWdata", lastWdata, {64{8'hA5}});
        checkOutput("wbMemAddr", LW'(lastMemAddr), LW'(64'h80));
        checkOutput("wbMemRd", LW'(memRdCycles), LW'(0));

        $display("[TB] UPGR from cache 3 with cache 1 sharing");
        clearStats();
        setSnoopRsp(1, BUS_RSP_SHARED, 1'b0, '0);
        pushExp(3, BUS_RSP_EXCL, '0);
        issueSingle(3, BUS_UPGR, BW'(64'hC0));
        setSnoopRsp(1, BUS_NO_RSP, 1'b0, '0);
        checkOutput("upgrSnoopVec", LW'(lastSnoop), LW'(snoopVec(3, BUS_UPGR)));
        checkOutput("upgrMemAccess", LW'(memRdCycles + memWrCycles), LW'(0));
        // First snoop cycle is cycle 1 after the grant edge.
        checkOutput("upgrLatency", LW'(rspCyc - firstSnoopCyc + 1), LW'(SL + 1));

        $display("[TB] caches 0,1,2 request together and keep re-requesting");
        clearStats();
        pushExp(0, BUS_RSP_EXCL, lineFor(BW'(64'h100)));
        pushExp(1, BUS_RSP_EXCL, lineFor(BW'(64'h101)));
        pushExp(2, BUS_RSP_EXCL, lineFor(BW'(64'h102)));
        pushExp(0, BUS_RSP_EXCL, lineFor(BW'(64'h100)));
        applyStimulus(0, BUS_RD, BW'(64'h100));
        applyStimulus(1, BUS_RD, BW'(64'h101));
        applyStimulus(2, BUS_RD, BW'(64'h102));
        n = 0;
        while (rspSeen < 4 && n < 300) begin
            nextCycle();
            n++;
        end
        cacReq = '0;
        waitDrain();
        repeat (10) nextCycle();
        checkOutput("rrRspCount", LW'(rspSeen), LW'(4));

        $display("[TB] RD from cache 0 with caches 1 and 2 both flushing");
        clearStats();
        setSnoopRsp(1, BUS_RSP_FLUSH, 1'b1, {64{8'h11}});
        setSnoopRsp(2, BUS_RSP_FLUSH, 1'b1, {64{8'h22}});
        pushExp(0, BUS_RSP_SHARED, {64{8'h11}});
        issueSingle(0, BUS_RD, BW'(64'h200));
        setSnoopRsp(1, BUS_NO_RSP, 1'b0, '0);
        setSnoopRsp(2, BUS_NO_RSP, 1'b0, '0);
        checkOutput("multiErrPulses", LW'(errPulses), LW'(1));
        checkOutput("multiWdata", lastWdata, {64{8'h11}});
        checkOutput("multiMemRd", LW'(memRdCycles), LW'(0));

        $display("[TB] reset asserted while a memory read is outstanding");
        clearStats();
        memEnable = 1'b0;
        memAck    = 1'b0;
        applyStimulus(2, BUS_RD, BW'(64'h300));
        waitSnoopStart();
        applyStimulus(2, BUS_NO_REQ, BW'(64'h300));
        n = 0;
        while (memRdCycles == 0 && n < 50) begin
            nextCycle();
            n++;
        end
        checkOutput("abortReachedMemRd", LW'(memRdCycles != 0), LW'(1));
        rst = 1'b1;
        #1;
        checkOutput("abortOutputs", LW'({memRd, memWr, |busReq, |busRsp, |busAddr,
                    |busData, |memAddr, |memWdata, errMulti}), '0);
        nextCycle();
        rst = 1'b0;
        clearStats();
        nextCycle();
        memAck   = 1'b1;
        memRdata = {64{8'hEE}};
        nextCycle();
        memAck = 1'b0;
        repeat (5) nextCycle();
        checkOutput("abortNoRsp", LW'(rspSeen), LW'(0));
        checkOutput("abortNoMem", LW'(memRdCycles + memWrCycles), LW'(0));
        memEnable = 1'b1;
        clearStats();
        pushExp(0, BUS_RSP_EXCL, '0);
        issueSingle(0, BUS_UPGR, BW'(64'h10));
        checkOutput("postAbortLatency", LW'(rspCyc - firstSnoopCyc + 1), LW'(SL + 1));

        checkOutput("rdWrOverlap", LW'(bothCycles), LW'(0));
        checkOutput("scoreboardEmpty", LW'(sbQueue.size()), LW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
